// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: two-requester round-robin front end for one shared
// combinational 8x8 unsigned multiplier. One transaction in flight at a time:
// IDLE accepts operands, CALC waits WAIT_CYCLES for the array to settle,
// RESP holds the product until the issuing requester takes it.
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid, once raised by the producer, holds its payload stable
// until that edge.
//
// Optional build macro: MULT_SHARE_ACC_EN adds reqN_acc inputs and a 16-bit
// per-requester accumulator (response = accN + product when reqN_acc was set
// at acceptance; accN takes the returned value on the response handshake).

// Purely combinational unsigned 8x8 array multiplier.
module multiply (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] m_o
);
  assign m_o = {8'd0, a_i} * {8'd0, b_i};
endmodule

module mult_share_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
`ifdef MULT_SHARE_ACC_EN
  input  logic        req0_acc,
  input  logic        req1_acc,
`endif
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [15:0] rsp0_m,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp1_m,
  output logic        busy,
  output logic        last_grant,
  output logic [1:0]  dbg_state
);

  // A settle time of 0 would skip the capture edge, so it is treated as 1.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd1 : 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  op_a_q;
  logic [7:0]  op_b_q;
  logic [3:0]  cnt_q;
  logic        last_grant_q;   // also the id of the transaction in flight
  logic        rsp0_valid_q;
  logic        rsp1_valid_q;
  logic [15:0] rsp0_m_q;
  logic [15:0] rsp1_m_q;
`ifdef MULT_SHARE_ACC_EN
  logic        acc_sel_q;
  logic [15:0] acc0_q;
  logic [15:0] acc1_q;
`endif

  logic        any_req;
  logic        grant_id;
  logic [15:0] mul_m;
  logic [15:0] result_d;
  logic        rsp_take;

  multiply u_multiply (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .m_o (mul_m)
  );

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    any_req    = req0_valid | req1_valid;
    grant_id   = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    req0_ready = (state_q == IDLE) & any_req & ~grant_id;
    req1_ready = (state_q == IDLE) & any_req & grant_id;
    rsp_take   = last_grant_q ? rsp1_ready : rsp0_ready;
  end

  // Value captured at the end of CALC: plain product or accumulated product.
  always_comb begin
    result_d = mul_m;
`ifdef MULT_SHARE_ACC_EN
    if (acc_sel_q) begin
      result_d = (last_grant_q ? acc1_q : acc0_q) + mul_m;
    end
`endif
  end

  // Sequencer: accept in IDLE, count down settle time in CALC, hold in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      op_a_q       <= 8'd0;
      op_b_q       <= 8'd0;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_m_q     <= 16'd0;
      rsp1_m_q     <= 16'd0;
`ifdef MULT_SHARE_ACC_EN
      acc_sel_q    <= 1'b0;
      acc0_q       <= 16'd0;
      acc1_q       <= 16'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            op_a_q       <= grant_id ? req1_a : req0_a;
            op_b_q       <= grant_id ? req1_b : req0_b;
            last_grant_q <= grant_id;
            cnt_q        <= WAIT_LOAD;
`ifdef MULT_SHARE_ACC_EN
            acc_sel_q    <= grant_id ? req1_acc : req0_acc;
`endif
            state_q      <= CALC;
          end
        end
        CALC: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (last_grant_q) begin
              rsp1_m_q     <= result_d;
              rsp1_valid_q <= 1'b1;
            end else begin
              rsp0_m_q     <= result_d;
              rsp0_valid_q <= 1'b1;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_take) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
`ifdef MULT_SHARE_ACC_EN
            if (last_grant_q) acc1_q <= rsp1_m_q;
            else              acc0_q <= rsp0_m_q;
`endif
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_m     = rsp0_m_q;
  assign rsp1_m     = rsp1_m_q;
  assign busy       = (state_q != IDLE);
  assign last_grant = last_grant_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level model (grant rule, latency, products).
module tb_mult_share_ctrl;

  localparam int WAIT = 2;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic        req0_acc, req1_acc;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [15:0] rsp0_m, rsp1_m;
  logic        busy, last_grant;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  mult_share_ctrl #(.WAIT_CYCLES(WAIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
`ifdef MULT_SHARE_ACC_EN
    .req0_acc   (req0_acc),
    .req1_acc   (req1_acc),
`endif
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_m     (rsp0_m),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_m     (rsp1_m),
    .busy       (busy),
    .last_grant (last_grant),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    req0_acc = 0; req1_acc = 0;
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    clear_inputs();
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
  endtask

  // Driver: one complete requester-0 transaction; returns product and timeout.
  task automatic do_txn0(input logic [7:0] a, input logic [7:0] b, input logic acc,
                         output logic [15:0] m, output bit to);
    bit got;
    to = 0; m = 16'd0;
    @(posedge clk); #1;
    req0_valid = 1; req0_a = a; req0_b = b; req0_acc = acc; rsp0_ready = 1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req0_ready === 1'b1) got = 1;
    end
    if (!got) to = 1;
    @(posedge clk); #1;
    req0_valid = 0; req0_acc = 0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (rsp0_valid === 1'b1) begin got = 1; m = rsp0_m; end
    end
    if (!got) to = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, last_grant} !== 6'b000001) begin
        failures++;
        $display("FAIL reset_flags: got r0r1v0v1busy_lg=%b want 000001",
                 {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, last_grant});
      end
    end
    checks++;
    if (rsp0_m !== 16'd0 || rsp1_m !== 16'd0) begin
      failures++;
      $display("FAIL reset_m: got m0=%0h m1=%0h want 0 0", rsp0_m, rsp1_m);
    end
  endtask

  task automatic test_single();
    int n;
    bit hit;
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 8'd15; req0_b = 8'd15; rsp0_ready = 1;
    @(negedge clk);
    checks++;
    if (!(req0_ready === 1'b1 && req1_ready === 1'b0)) begin
      failures++;
      $display("FAIL single_ready: got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 0; req0_a = 0; req0_b = 0;
    n = 0; hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        checks++;
        if ({req0_ready, busy} !== 2'b01) begin
          failures++;
          $display("FAIL single_calc: got ready=%b busy=%b want ready=0 busy=1", req0_ready, busy);
        end
      end
      if (rsp0_valid === 1'b1) hit = 1;
    end
    checks++;
    if (!hit || n != WAIT + 1) begin
      failures++;
      $display("FAIL single_latency: got %0d edges (seen=%0d) want %0d", n, hit, WAIT + 1);
    end
    checks++;
    if (rsp0_m !== 16'd225) begin
      failures++;
      $display("FAIL single_m: got %0d want 225", rsp0_m);
    end
    checks++;
    if (rsp1_valid !== 1'b0 || last_grant !== 1'b0) begin
      failures++;
      $display("FAIL single_other: got v1=%b lg=%b want v1=0 lg=0", rsp1_valid, last_grant);
    end
    @(negedge clk);
    checks++;
    if ({rsp0_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL single_done: got valid=%b busy=%b want 0 0", rsp0_valid, busy);
    end
  endtask

  task automatic test_tie();
    bit hit, bad1;
    do_reset();
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 8'd255; req0_b = 8'd255;
    req1_valid = 1; req1_a = 8'd15;  req1_b = 8'd240;
    rsp0_ready = 1; rsp1_ready = 1;
    @(negedge clk);
    checks++;
    if (!(req0_ready === 1'b1 && req1_ready === 1'b0)) begin
      failures++;
      $display("FAIL tie_grant: got r0=%b r1=%b want r0=1 r1=0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 0;
    hit = 0; bad1 = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (rsp1_valid === 1'b1 || req1_ready === 1'b1) bad1 = 1;
      if (rsp0_valid === 1'b1) hit = 1;
    end
    checks++;
    if (!hit || rsp0_m !== 16'hFE01) begin
      failures++;
      $display("FAIL tie_m0: got %0d (seen=%0d) want 65025", rsp0_m, hit);
    end
    checks++;
    if (bad1) begin
      failures++;
      $display("FAIL tie_no_rsp1: got req1 activity during req0 txn want none");
    end
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL tie_next_grant: got r1=%b want 1", req1_ready);
    end
    @(posedge clk); #1;
    req1_valid = 0;
    hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (rsp1_valid === 1'b1) hit = 1;
    end
    checks++;
    if (!hit || rsp1_m !== 16'd3600) begin
      failures++;
      $display("FAIL tie_m1: got %0d (seen=%0d) want 3600", rsp1_m, hit);
    end
    @(negedge clk);
    checks++;
    if (last_grant !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL tie_end: got lg=%b busy=%b want lg=1 busy=0", last_grant, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  a, b;
    logic [15:0] exp_m, held;
    bit hit;
    a = 8'($urandom_range(1, 255));
    b = 8'($urandom_range(1, 255));
    exp_m = 16'(a) * 16'(b);
    @(posedge clk); #1;
    req1_valid = 1; req1_a = a; req1_b = b; rsp1_ready = 0;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_grant1: got r1=%b want 1", req1_ready);
    end
    @(posedge clk); #1;
    req1_valid = 0;
    req0_valid = 1; req0_a = 8'd7; req0_b = 8'd9; rsp0_ready = 1;
    hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (rsp1_valid === 1'b1) hit = 1;
    end
    held = rsp1_m;
    checks++;
    if (!hit || held !== exp_m) begin
      failures++;
      $display("FAIL bp_m1: got %0d (seen=%0d) want %0d", held, hit, exp_m);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (rsp1_valid !== 1'b1 || rsp1_m !== exp_m || req0_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold: got v1=%b m1=%0d r0=%b want v1=1 m1=%0d r0=0",
                 rsp1_valid, rsp1_m, req0_ready, exp_m);
      end
    end
    @(posedge clk); #1;
    rsp1_ready = 1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b0 || rsp1_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_hs_cycle: got r0=%b v1=%b want r0=0 v1=1", req0_ready, rsp1_valid);
    end
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1 || rsp1_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_after_hs: got r0=%b v1=%b want r0=1 v1=0", req0_ready, rsp1_valid);
    end
    @(posedge clk); #1;
    req0_valid = 0; rsp1_ready = 0;
    hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (rsp0_valid === 1'b1) hit = 1;
    end
    checks++;
    if (!hit || rsp0_m !== 16'd63) begin
      failures++;
      $display("FAIL bp_m0: got %0d (seen=%0d) want 63", rsp0_m, hit);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 8'd12; req0_b = 8'd12; rsp0_ready = 1;
    @(negedge clk);
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL rmid_grant: got r0=%b want 1", req0_ready);
    end
    @(posedge clk); #1;
    req0_valid = 0;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, last_grant} !== 6'b000001 ||
        rsp0_m !== 16'd0 || rsp1_m !== 16'd0) begin
      failures++;
      $display("FAIL rmid_outputs: got flags=%b m0=%0d m1=%0d want 000001 0 0",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, last_grant}, rsp0_m, rsp1_m);
    end
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp0_valid === 1'b1 || busy === 1'b1) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL rmid_no_rsp: got response/busy after reset want none");
    end
    rsp0_ready = 0;
  endtask

  // Scoreboard: grant rule, latency and products at transaction level.
  task automatic test_random();
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    bit in_flight, fl_id, lg_m;
    bit exp_any, exp_id, obs_any, exp_v;
    int cyc, acc_cyc;
    logic [15:0] want;
    do_reset();
    in_flight = 0; fl_id = 0; lg_m = 1; cyc = 0; acc_cyc = 0;
    for (int i = 0; i < 430; i++) begin
      @(posedge clk); #1;
      if (i < 400) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req1_valid = ($urandom_range(0, 2) != 0);
        req0_a = 8'($urandom_range(0, 255)); req0_b = 8'($urandom_range(0, 255));
        req1_a = 8'($urandom_range(0, 255)); req1_b = 8'($urandom_range(0, 255));
        rsp0_ready = 1'($urandom_range(0, 1));
        rsp1_ready = 1'($urandom_range(0, 1));
      end else begin
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
      end
      @(negedge clk);
      cyc++;
      exp_any = !in_flight && (req0_valid || req1_valid);
      exp_id  = (req0_valid && req1_valid) ? !lg_m : req1_valid;
      obs_any = req0_ready | req1_ready;
      checks++;
      if ((req0_ready & req1_ready) !== 1'b0 || obs_any !== exp_any) begin
        failures++;
        $display("FAIL rnd_ready cyc=%0d: got r0=%b r1=%b want any=%b", cyc, req0_ready, req1_ready, exp_any);
      end else if (obs_any) begin
        checks++;
        if (req1_ready !== exp_id) begin
          failures++;
          $display("FAIL rnd_grant cyc=%0d: got id=%b want %b", cyc, req1_ready, exp_id);
        end
        if (req1_ready) exp_q1.push_back(16'(req1_a) * 16'(req1_b));
        else            exp_q0.push_back(16'(req0_a) * 16'(req0_b));
        in_flight = 1; fl_id = req1_ready; lg_m = req1_ready; acc_cyc = cyc;
      end
      exp_v = in_flight && (cyc - acc_cyc >= WAIT + 1);
      checks++;
      if ({rsp1_valid, rsp0_valid} !== {exp_v && fl_id, exp_v && !fl_id}) begin
        failures++;
        $display("FAIL rnd_valid cyc=%0d: got v1v0=%b%b want %b%b", cyc, rsp1_valid, rsp0_valid,
                 exp_v && fl_id, exp_v && !fl_id);
      end else if (exp_v) begin
        want = fl_id ? ((exp_q1.size() > 0) ? exp_q1[0] : 16'hxxxx)
                     : ((exp_q0.size() > 0) ? exp_q0[0] : 16'hxxxx);
        checks++;
        if ((fl_id ? rsp1_m : rsp0_m) !== want) begin
          failures++;
          $display("FAIL rnd_m cyc=%0d id=%0d: got %0d want %0d", cyc, fl_id,
                   fl_id ? rsp1_m : rsp0_m, want);
        end
        if (fl_id ? rsp1_ready : rsp0_ready) begin
          if (fl_id) void'(exp_q1.pop_front());
          else       void'(exp_q0.pop_front());
          in_flight = 0;
        end
      end
    end
    checks++;
    if (in_flight || exp_q0.size() != 0 || exp_q1.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rnd_drain: got pending q0=%0d q1=%0d busy=%b want 0 0 0",
               exp_q0.size(), exp_q1.size(), busy);
    end
  endtask

`ifdef MULT_SHARE_ACC_EN
  task automatic test_acc();
    logic [15:0] m;
    bit to;
    do_reset();
    do_txn0(8'd10, 8'd10, 1'b0, m, to);
    checks++;
    if (to || m !== 16'd100) begin
      failures++;
      $display("FAIL acc_1: got %0d (timeout=%0d) want 100", m, to);
    end
    do_txn0(8'd200, 8'd200, 1'b1, m, to);
    checks++;
    if (to || m !== 16'd40100) begin
      failures++;
      $display("FAIL acc_2: got %0d (timeout=%0d) want 40100", m, to);
    end
    do_txn0(8'd255, 8'd255, 1'b1, m, to);
    checks++;
    if (to || m !== 16'd39589) begin
      failures++;
      $display("FAIL acc_3: got %0d (timeout=%0d) want 39589", m, to);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef MULT_SHARE_ACC_EN
    test_acc();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Sequencing controller and two-requester arbiter for one shared 8x8 unsigned array multiplier instance (`multiply`: M[15:0] = A*B).
- The multiplier is purely combinational, so the controller registers operands and waits a fixed settle time before capturing the product.
- It returns each product to the requester that issued it through a valid/ready response channel.
- It sits between the two datapath clients and the multiplier; only one transaction is in flight at a time.

Parameters:
- WAIT_CYCLES, 2, number of CALC cycles allowed for the array to settle; legal 1..15; 0 behaves as 1.

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has operands
- req0_ready  output  1  requester 0 operands accepted this cycle
- req0_a  input  8  requester 0 multiplicand
- req0_b  input  8  requester 0 multiplier
- req1_valid, req1_ready, req1_a, req1_b: same as requester 0, for requester 1
- rsp0_valid  output  1  product for requester 0 available
- rsp0_ready  input  1  requester 0 takes the product
- rsp0_m  output  16  product for requester 0
- rsp1_valid, rsp1_ready, rsp1_m: same as requester 0, for requester 1
- busy  output  1  high whenever state != IDLE
- last_grant  output  1  id of the most recently granted requester

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE; all valid/ready outputs 0; rsp*_m=0; busy=0.
  - last_grant=1, so requester 0 wins the first tie.
  - Operand, result and counter registers cleared.
  - Reset mid-CALC or mid-RESP discards the transaction; no response is ever issued for it.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Grant rule: if exactly one reqN_valid is high, grant N. If both are high, grant !last_grant (round-robin).
  - reqN_ready is combinational: high only in IDLE for the granted N. Never high for both; never high outside IDLE.
  - On the acceptance edge: latch a/b into operand registers, set last_grant=N, load counter=WAIT_CYCLES, go to CALC.
  - If no request is valid, stay in IDLE.
- CALC:
  - Operand registers drive the multiplier; counter decrements each edge.
  - At the edge where counter==1: capture the multiplier output into the result register and go to RESP.
  - CALC therefore spans exactly WAIT_CYCLES cycles.
- RESP:
  - rspN_valid=1 for the granted N only; rspN_m = result register.
  - rspN_m is stable while valid is high.
  - On the edge where rspN_ready is high, drop valid and go to IDLE.
  - rsp_ready of the non-granted requester is ignored.
- Latency:
  - Acceptance edge to first rsp_valid cycle: WAIT_CYCLES+1 edges (e.g. 3 edges with the default).
  - Minimum spacing between two acceptances: WAIT_CYCLES+2 cycles.
- Requester rules:
  - A requester may drop valid before it is granted; nothing happens.
  - Operands are sampled only on the acceptance edge.
- Arithmetic:
  - Unsigned 8x8 -> 16-bit product, no truncation.
  - 255*255 = 65025 (0xFE01).
- Simultaneous events:
  - A new request arriving during CALC/RESP waits; ready stays low.
  - A response handshake and a new request in the same cycle: the handshake completes first; the new request is accepted no earlier than the next cycle (in IDLE).

Optional Feature:
- Macro: MULT_SHARE_ACC_EN.
- Defined:
  - Each requester gets an extra input reqN_acc (1 bit) and a 16-bit per-requester accumulator, reset to 0.
  - If reqN_acc=1 at acceptance, the response is accN + product (mod 2^16, wrap silently). Otherwise it is the plain product.
  - accN is updated with the returned value on the rspN handshake.
  - Accumulation adds no latency: the add happens on the CALC capture edge.
- Undefined: the reqN_acc ports and accumulators do not exist; response is always the plain product.

Test Plan:
- Reset, then idle 5 cycles -> all ready/valid 0, busy 0, last_grant 1, rsp*_m 0.
- req0 a=15 b=15, WAIT_CYCLES=2, rsp0_ready held 1 -> req0_ready pulses 1 cycle; rsp0_valid high 3 edges after acceptance; rsp0_m=225; busy falls the next cycle.
- req0 (255,255) and req1 (15,240) raised in the same cycle -> req0 served first, rsp0_m=65025; then req1, rsp1_m=3600; last_grant ends at 1; rsp1_valid never high during the req0 transaction.
- Backpressure: rsp1_ready low for 5 cycles while req0_valid is high -> rsp1_valid and rsp1_m stable, req0_ready stays 0; after the handshake, req0 is accepted on the next IDLE cycle.
- rst asserted in the 2nd CALC cycle of a req0 (12,12) transaction -> all outputs 0 on the next cycle; no rsp0_valid ever appears for that request.
- MULT_SHARE_ACC_EN: three req0 transactions (10,10), (200,200) acc=1, (255,255) acc=1 -> expected rsp0_m values 100, 40100, (40100+65025) mod 65536 = 39589.
